result_display: RTL and testbench

RESULT_DISPLAY -- requirements
Module: result_display

---
 rtl/result_display.sv | 152 +++++++++++++++
 tb/tb_result_display.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/result_display.sv
// Debounced 7-segment display of a 3-bit result: blanks after reset or a sel change,
// commits a value once it has been stable for STABLE_CYCLES samples. Optional history: RESULT_DISPLAY_HIST_EN.
module result_display #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned BLANK_CYCLES  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [2:0]  result,
  output logic [6:0]  seg,
  output logic        valid,
  output logic        changed,
  output logic [7:0]  commits
`ifdef RESULT_DISPLAY_HIST_EN
  ,
  output logic [11:0] hist
`endif
);

  typedef enum logic [1:0] {BLANK, FILTER, SHOW} state_t;

  localparam logic [3:0] SLAST = 4'(STABLE_CYCLES - 1);
  localparam logic [7:0] BLAST = 8'(BLANK_CYCLES - 1);

  state_t      state, state_n;
  logic        sel_q;
  logic [2:0]  cand, cand_n;
  logic [2:0]  disp, disp_n;
  logic [3:0]  scnt, scnt_n;
  logic [7:0]  bcnt, bcnt_n;
  logic [6:0]  seg_n;
  logic        valid_n;
  logic        changed_n;
  logic [7:0]  commits_n;
  logic        commit;
`ifdef RESULT_DISPLAY_HIST_EN
  logic [11:0] hist_n;
`endif

  function automatic logic [6:0] enc(input logic [2:0] v);
    case (v)
      3'd0:    enc = 7'h40;
      3'd1:    enc = 7'h79;
      3'd2:    enc = 7'h24;
      3'd3:    enc = 7'h30;
      3'd4:    enc = 7'h19;
      3'd5:    enc = 7'h12;
      3'd6:    enc = 7'h02;
      default: enc = 7'h78;
    endcase
  endfunction

  always_comb begin
    state_n   = state;
    cand_n    = cand;
    disp_n    = disp;
    scnt_n    = scnt;
    bcnt_n    = bcnt;
    seg_n     = seg;
    valid_n   = valid;
    changed_n = 1'b0;
    commits_n = commits;
    commit    = 1'b0;
`ifdef RESULT_DISPLAY_HIST_EN
    hist_n    = hist;
`endif
    // A sel change pre-empts everything else, including a commit due on this edge.
    if (sel != sel_q) begin
      state_n = BLANK;
      bcnt_n  = '0;
      valid_n = 1'b0;
      seg_n   = 7'h7F;
    end else begin
      case (state)
        BLANK: begin
          if (bcnt == BLAST) begin
            cand_n  = result;
            scnt_n  = 4'd1;
            state_n = FILTER;
          end else begin
            bcnt_n = bcnt + 8'd1;
          end
        end
        FILTER: begin
          if (result == cand) begin
            if (scnt == SLAST) begin
              commit  = 1'b1;
              state_n = SHOW;
            end else begin
              scnt_n = scnt + 4'd1;
            end
          end else begin
            cand_n = result;
            scnt_n = 4'd1;
          end
        end
        SHOW: begin
          if (result != disp) begin
            cand_n  = result;
            scnt_n  = 4'd1;
            state_n = FILTER;
          end
        end
        default: state_n = BLANK;
      endcase
    end

    if (commit) begin
      disp_n    = cand;
      valid_n   = 1'b1;
      changed_n = 1'b1;
      seg_n     = enc(cand);
      commits_n = (commits == 8'hFF) ? commits : commits + 8'd1;
`ifdef RESULT_DISPLAY_HIST_EN
      hist_n    = {hist[8:0], cand};
`endif
    end
  end

  always_ff @(posedge clk) begin
    sel_q <= sel;
    if (rst) begin
      state   <= BLANK;
      bcnt    <= '0;
      scnt    <= '0;
      cand    <= '0;
      disp    <= '0;
      seg     <= 7'h7F;
      valid   <= 1'b0;
      changed <= 1'b0;
      commits <= '0;
`ifdef RESULT_DISPLAY_HIST_EN
      hist    <= '0;
`endif
    end else begin
      state   <= state_n;
      bcnt    <= bcnt_n;
      scnt    <= scnt_n;
      cand    <= cand_n;
      disp    <= disp_n;
      seg     <= seg_n;
      valid   <= valid_n;
      changed <= changed_n;
      commits <= commits_n;
`ifdef RESULT_DISPLAY_HIST_EN
      hist    <= hist_n;
`endif
    end
  end

endmodule

// File: tb/tb_result_display.sv
// Directed self-checking bench for result_display with default parameters.
module tb_result_display;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [2:0]  result;
  logic [6:0]  seg;
  logic        valid;
  logic        changed;
  logic [7:0]  commits;
`ifdef RESULT_DISPLAY_HIST_EN
  logic [11:0] hist;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  result_display #(.STABLE_CYCLES(4), .BLANK_CYCLES(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .result  (result),
    .seg     (seg),
    .valid   (valid),
    .changed (changed),
    .commits (commits)
`ifdef RESULT_DISPLAY_HIST_EN
    ,
    .hist    (hist)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] r);
    rst = 1'b1; sel = 1'b0; result = r;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 1'b0; result = 3'd5;
    tick();
    n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg got %h want 7f", seg); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid); end
    n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL reset_changed got %b want 0", changed); end
    n_cmp++; if (commits !== 8'd0) begin n_bad++; $display("FAIL reset_commits got %0d want 0", commits); end
    rst = 1'b0;
  endtask

  // 8 blanking edges, cand loaded on the 8th, commit 3 edges later (11th edge).
  task automatic test_first_commit();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (seg !== 7'h7F || valid !== 1'b0 || changed !== 1'b0) begin
        n_bad++; $display("FAIL blank_hold cyc %0d got seg=%h valid=%b changed=%b want 7f/0/0", i, seg, valid, changed);
      end
    end
    tick();
    n_cmp++; if (seg !== 7'h12) begin n_bad++; $display("FAIL first_seg got %h want 12", seg); end
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL first_valid got %b want 1", valid); end
    n_cmp++; if (changed !== 1'b1) begin n_bad++; $display("FAIL first_changed got %b want 1", changed); end
    n_cmp++; if (commits !== 8'd1) begin n_bad++; $display("FAIL first_commits got %0d want 1", commits); end
    tick();
    n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL first_pulse_len got %b want 0", changed); end
    n_cmp++; if (seg !== 7'h12) begin n_bad++; $display("FAIL first_seg_hold got %h want 12", seg); end
  endtask

  // 3-cycle glitch to 2 never shows; the return to 5 is re-committed as an equal value.
  task automatic test_glitch();
    result = 3'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (seg !== 7'h12 || changed !== 1'b0 || valid !== 1'b1) begin
        n_bad++; $display("FAIL glitch cyc %0d got seg=%h changed=%b valid=%b want 12/0/1", i, seg, changed, valid);
      end
    end
    result = 3'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (seg !== 7'h12 || changed !== 1'b0 || commits !== 8'd1) begin
        n_bad++; $display("FAIL glitch_back cyc %0d got seg=%h changed=%b commits=%0d want 12/0/1", i, seg, changed, commits);
      end
    end
    tick();
    n_cmp++; if (changed !== 1'b1) begin n_bad++; $display("FAIL recommit_changed got %b want 1", changed); end
    n_cmp++; if (commits !== 8'd2) begin n_bad++; $display("FAIL recommit_commits got %0d want 2", commits); end
    n_cmp++; if (seg !== 7'h12) begin n_bad++; $display("FAIL recommit_seg got %h want 12", seg); end
  endtask

  task automatic test_sel_change();
    sel = 1'b1; result = 3'd4;
    tick();
    n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL sel_seg got %h want 7f", seg); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL sel_valid got %b want 0", valid); end
    n_cmp++; if (commits !== 8'd2) begin n_bad++; $display("FAIL sel_commits_kept got %0d want 2", commits); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (seg !== 7'h7F || changed !== 1'b0) begin
        n_bad++; $display("FAIL sel_blank cyc %0d got seg=%h changed=%b want 7f/0", i, seg, changed);
      end
    end
    tick();
    n_cmp++; if (seg !== 7'h19) begin n_bad++; $display("FAIL sel_new_seg got %h want 19", seg); end
    n_cmp++; if (changed !== 1'b1) begin n_bad++; $display("FAIL sel_new_changed got %b want 1", changed); end
    n_cmp++; if (commits !== 8'd3) begin n_bad++; $display("FAIL sel_new_commits got %0d want 3", commits); end
  endtask

  task automatic test_sel_priority();
    result = 3'd6;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL prio_pre got %b want 0", changed); end
    sel = 1'b0;
    tick();
    n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL prio_changed got %b want 0", changed); end
    n_cmp++; if (commits !== 8'd3) begin n_bad++; $display("FAIL prio_commits got %0d want 3", commits); end
    n_cmp++; if (seg !== 7'h7F || valid !== 1'b0) begin n_bad++; $display("FAIL prio_blank got seg=%h valid=%b want 7f/0", seg, valid); end
  endtask

  task automatic test_rst_on_commit();
    do_reset(3'd7);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL rstc_changed got %b want 0", changed); end
    n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL rstc_seg got %h want 7f", seg); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rstc_valid got %b want 0", valid); end
    n_cmp++; if (commits !== 8'd0) begin n_bad++; $display("FAIL rstc_commits got %0d want 0", commits); end
    tick();
    n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL rstc_after got %b want 0", changed); end
  endtask

  task automatic test_saturate();
    logic [2:0] v;
    logic [7:0] exp_c;
    do_reset(3'd0);
    for (int i = 0; i < 11; i++) tick();
    n_cmp++; if (commits !== 8'd1 || changed !== 1'b1 || seg !== 7'h40) begin
      n_bad++; $display("FAIL sat_first got commits=%0d changed=%b seg=%h want 1/1/40", commits, changed, seg);
    end
    for (int k = 2; k <= 300; k++) begin
      v = k[0] ? 3'd0 : 3'd1;
      exp_c = (k > 255) ? 8'd255 : 8'(k);
      result = v;
      for (int i = 0; i < 3; i++) tick();
      n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL sat_quiet k=%0d got %b want 0", k, changed); end
      tick();
      n_cmp++;
      if (changed !== 1'b1 || commits !== exp_c || seg !== (k[0] ? 7'h40 : 7'h79)) begin
        n_bad++; $display("FAIL sat_commit k=%0d got changed=%b commits=%0d seg=%h want 1/%0d/%h",
                          k, changed, commits, seg, exp_c, k[0] ? 7'h40 : 7'h79);
      end
    end
  endtask

`ifdef RESULT_DISPLAY_HIST_EN
  task automatic test_hist();
    do_reset(3'd1);
    n_cmp++; if (hist !== 12'h000) begin n_bad++; $display("FAIL hist_reset got %h want 000", hist); end
    for (int i = 0; i < 11; i++) tick();
    n_cmp++; if (hist !== 12'h001) begin n_bad++; $display("FAIL hist_one got %h want 001", hist); end
    for (int v = 2; v <= 5; v++) begin
      result = 3'(v);
      for (int i = 0; i < 4; i++) tick();
    end
    n_cmp++; if (hist !== 12'h4E5) begin n_bad++; $display("FAIL hist_final got %h want 4e5", hist); end
    n_cmp++; if (commits !== 8'd5) begin n_bad++; $display("FAIL hist_commits got %0d want 5", commits); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_commit();
    test_glitch();
    test_sel_change();
    test_sel_priority();
    test_rst_on_commit();
    test_saturate();
`ifdef RESULT_DISPLAY_HIST_EN
    test_hist();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
